mul_wb_buffer: RTL

MUL_WB_BUFFER -- requirements
Module: mul_wb_buffer

---
 rtl/mul_wb_buffer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mul_wb_buffer.sv
// Multiplier writeback buffer: tracks issued-op destination tags and queues results for writeback.
// Optional macro MUL_WB_BYPASS_EN adds a same-cycle multiplier-to-writeback path when the queue is empty.
module mul_wb_buffer #(
   parameter int TAG_W = 5,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_fire_i,
   input  logic             issue_wreg_i,
   input  logic [TAG_W-1:0] issue_waddr_i,
   input  logic             mul_done_i,
   input  logic [31:0]      mul_result_i,
   output logic             mul_ack_o,
   output logic             wb_valid_o,
   input  logic             wb_ready_i,
   output logic             wb_wreg_o,
   output logic [TAG_W-1:0] wb_waddr_o,
   output logic [31:0]      wb_wdata_o,
   input  logic             flush_i,
   output logic             tag_full_o,
   output logic             err_o
);
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic             wreg;
      logic [TAG_W-1:0] waddr;
      logic [31:0]      wdata;
   } res_t;

   // Two-slot tag FIFO; kill bits live apart from the payload so they can be reset and flushed.
   logic [TAG_W-1:0] tag_waddr [2];
   logic [1:0]       tag_wreg;
   logic [1:0]       tag_kill;
   logic             tag_rd, tag_wr;
   logic [1:0]       tag_cnt;
   logic             tag_empty, tag_full, head_kill, tag_push, tag_pop;

   res_t             res_mem [DEPTH];
   logic [PW-1:0]    res_rd, res_wr;
   logic [PW:0]      res_cnt;
   logic             res_empty, res_full, res_push, res_pop, bypass;
   res_t             res_head;

   assign tag_empty  = (tag_cnt == 2'd0);
   assign tag_full   = (tag_cnt == 2'd2);
   assign head_kill  = tag_kill[tag_rd];
   assign tag_full_o = tag_full;
   assign res_empty  = (res_cnt == '0);
   assign res_full   = (res_cnt == (PW+1)'(DEPTH));
   assign res_head   = res_mem[res_rd];

   // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      bypass = 1'b0;
`ifdef MUL_WB_BYPASS_EN
      bypass = mul_done_i & ~tag_empty & ~head_kill & res_empty & ~flush_i;
`endif
      // An orphan result (no tag) is always consumed so the multiplier can never wedge.
      mul_ack_o  = rst_n & mul_done_i & (tag_empty | head_kill | ~res_full);
      tag_pop    = mul_ack_o & ~tag_empty;
      tag_push   = issue_fire_i & (~tag_full | tag_pop);
      res_push   = tag_pop & ~head_kill & ~flush_i & ~(bypass & wb_ready_i);
      res_pop    = ~res_empty & wb_ready_i;
      wb_valid_o = ~res_empty | bypass;
      wb_wreg_o  = 1'b0;
      wb_waddr_o = '0;
      wb_wdata_o = '0;
      if (!res_empty) begin
         wb_wreg_o  = res_head.wreg;
         wb_waddr_o = res_head.waddr;
         wb_wdata_o = res_head.wdata;
      end else if (bypass) begin
         wb_wreg_o  = tag_wreg[tag_rd];
         wb_waddr_o = tag_waddr[tag_rd];
         wb_wdata_o = mul_result_i;
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_rd   <= 1'b0;
         tag_wr   <= 1'b0;
         tag_cnt  <= 2'd0;
         tag_kill <= 2'b00;
      end else begin
         if (flush_i) tag_kill <= 2'b11;
         // The flush-cycle push lands after the blanket kill, so that op survives.
         if (tag_push) begin
            tag_kill[tag_wr] <= 1'b0;
            tag_wr           <= ~tag_wr;
         end
         if (tag_pop) tag_rd <= ~tag_rd;
         tag_cnt <= tag_cnt + 2'(tag_push) - 2'(tag_pop);
      end
   end

   // NOTE: payload storage is not reset; occupancy counters alone decide what is valid, and outputs are gated by them.
   always_ff @(posedge clk) begin
      if (tag_push) begin
         tag_wreg[tag_wr]  <= issue_wreg_i;
         tag_waddr[tag_wr] <= issue_waddr_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_rd  <= '0;
         res_wr  <= '0;
         res_cnt <= '0;
      end else if (flush_i) begin
         res_rd  <= '0;
         res_wr  <= '0;
         res_cnt <= '0;
      end else begin
         if (res_push) res_wr <= res_wr + PW'(1);
         if (res_pop)  res_rd <= res_rd + PW'(1);
         res_cnt <= res_cnt + (PW+1)'(res_push) - (PW+1)'(res_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (res_push) res_mem[res_wr] <= '{wreg: tag_wreg[tag_rd], waddr: tag_waddr[tag_rd], wdata: mul_result_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_o <= 1'b0;
      end else if ((mul_done_i & tag_empty) | (issue_fire_i & tag_full & ~tag_pop)) begin
         err_o <= 1'b1;
      end
   end

endmodule
